// File: rtl/countdown_timer_ctrl_pkg.sv
// rtl/countdown_timer_ctrl_pkg.sv - shared types and defaults for the countdown timer controller
package countdown_timer_ctrl_pkg;

  localparam int DATAWIDTH_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_RUN) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_divider.sv
// rtl/countdown_timer_ctrl_tick_divider.sv - prescaler producing a registered one-cycle tick
module tick_divider #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count;

  // tick is registered on the wrap edge so it appears on the cycle after the last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - timer FSM driving an external loadable up/down counter
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int PRESCALE  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 clear,
  input  logic                 mode_down,
  input  logic [DATAWIDTH-1:0] preset,
  input  logic [DATAWIDTH-1:0] cnt_value,
  output logic                 cnt_load,
  output logic [DATAWIDTH-1:0] cnt_load_value,
  output logic                 cnt_down,
  output logic                 cnt_step,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [DATAWIDTH-1:0] cap_preset;
  logic                 cap_down;
  logic                 capture;
  logic                 at_target;
  logic                 presc_en;
  logic                 presc_clr;

  assign capture   = ((state == S_IDLE) || (state == S_DONE)) && start && !clear;
  assign at_target = (cnt_value == (cap_down ? '0 : cap_preset));
  assign presc_clr = clear || capture;
  // The LOAD cycle counts toward the first period so the first step lands PRESCALE cycles after LOAD
  assign presc_en  = (state == S_LOAD) || ((state == S_RUN) && !at_target && !pause);
  assign cnt_down  = cap_down;

  tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .en  (presc_en),
    .clr (presc_clr),
    .tick(cnt_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cap_preset     <= '0;
      cap_down       <= 1'b0;
      cnt_load       <= 1'b0;
      cnt_load_value <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      cnt_load <= 1'b0;
      if (clear) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state          <= S_LOAD;
              cap_preset     <= preset;
              cap_down       <= mode_down;
              cnt_load_value <= mode_down ? preset : '0;
              cnt_load       <= 1'b1;
              busy           <= 1'b1;
              done           <= 1'b0;
            end
          end
          S_LOAD: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (at_target) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (pause) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!pause) state <= S_RUN;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
